fft8_input_framer: RTL and testbench
====================================

// Module: fft8_input_framer
// PURPOSE
//  Upstream feeder for the 8-point 16-bit FFT core. Collects a serial stream of
//  16-bit real samples into 8-sample frames using two banks (ping-pong), and
//  presents a completed frame in parallel on x0..x7 with valid/ready handshake.
//  One bank fills while the other is held stable for the FFT. Sits between the
//  sample source (ADC/UART/BRAM reader) and the FFT inputs.
// PARAMETERS
//  DW      16   sample width, bits
//  NPT     8    samples per frame; fixed at 8, other values unsupported
//  ERRW    8    width of the saturating frame-error counter
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  rst          in   1      synchronous, active-high reset
//  en           in   1      global clock enable; low freezes all state
//  s_data       in   DW     input sample
//  s_valid      in   1      s_data valid
//  s_last       in   1      source end-of-frame marker (optional, checked)
//  s_ready      out  1      framer can accept s_data this cycle
//  x0..x7       out  DW     parallel frame, x0 = first sample received
//  frame_valid  out  1      x0..x7 hold a complete frame
//  frame_ready  in   1      consumer takes the frame this cycle
//  frame_err    out  1      1-cycle pulse: partial frame discarded
//  err_cnt      out  ERRW   saturating count of frame_err pulses
// BEHAVIOUR
//  Reset: both banks cleared to 0, wr_idx=0, wr_bank=0, rd_bank=0, both
//   bank_full=0. Outputs: x0..x7=0, frame_valid=0, s_ready=0 during rst,
//   frame_err=0, err_cnt=0. Asserting rst mid-frame discards any partial or held
//   frame. No frame_err is raised.
//  Accept: s_valid & s_ready & en. s_ready = en & ~rst & ~bank_full[wr_bank]
//   (combinational from registers). Writes s_data to bank[wr_bank][wr_idx] and
//   increments wr_idx.
//  Write FSM (per wr_bank):
//   FILL: accepting.
//   WAIT: bank_full[wr_bank]=1, s_ready=0.
//   FILL->WAIT when wr_idx==7 is accepted and the other bank is still full.
//  Completion (accept at wr_idx==7, any s_last): bank_full[wr_bank]<=1,
//   wr_bank toggles, wr_idx<=0.
//  s_last accepted at wr_idx<7: partial frame discarded. wr_idx<=0, wr_bank
//   unchanged, bank not marked full, frame_err pulses next cycle, err_cnt+1
//   (saturates at all-ones).
//  Read side: frame_valid = bank_full[rd_bank]; x0..x7 = bank[rd_bank], muxed
//   from registers. Outputs are stable while frame_valid=1 and not yet taken.
//  Release: frame_valid & frame_ready & en -> bank_full[rd_bank]<=0,
//   rd_bank toggles.
//  Latency: 8th sample accepted in cycle n -> frame_valid=1 in cycle n+1 when
//   the bank is at the read head. Full throughput: 1 sample/cycle, no bubbles,
//   when frame_ready=1.
//  Simultaneous events:
//   - Release of one bank and completion of the other in the same cycle: both
//     apply. frame_valid stays 1 and x switches to the new frame next cycle.
//   - Release and new write to the same bank cannot coincide, because s_ready
//     is 0 for a full bank.
//   - frame_err and completion are mutually exclusive by construction.
//  en=0: no accepts, no releases, no counter changes. frame_err held 0.
//   Outputs keep their values.
//  Arithmetic: sample data is not modified (no scaling or sign handling).
//   wr_idx is 3 bits and wraps 7->0 only on completion/discard.
// STRUCTURE
//  Shared header fft_defs.vh: FFT_NPT=8, FFT_DW=16, FFT_IDXW=3. This header is
//   also used by the FFT core and the downstream output stage.
//  Sub-module fft8_frame_bank: 8 x DW register file with write port (we, idx,
//   data), synchronous clear, and 8 parallel read outputs. Instantiated twice.
//   The top level holds the write FSM, read pointer, mux, and error logic.
// TESTING
//  1. Reset, then stream 1..8, one sample/cycle, frame_ready=1
//     -> frame_valid high one cycle after 8th accept, x0..x7=1..8, low next cycle.
//  2. frame_ready=0, stream 1..17
//     -> s_ready drops after the 16th accept, 17th stalls.
//     Raise frame_ready -> frame 1..8, then 9..16; 17 accepted once a bank frees.
//  3. s_last on 5th sample (0x0100..0x0104)
//     -> frame_err 1-cycle pulse, err_cnt=1, no frame_valid.
//     Next 8 samples 0x0200..0x0207 appear as x0..x7.
//  4. en=0 for 3 cycles mid-frame with s_valid=1
//     -> no accepts, state frozen. Final frame identical to test 1.
//  5. rst after 4 of 8 samples
//     -> s_ready=1 on the cycle after rst drops, x=0, frame_valid=0.
//     Next 8 samples form a clean frame.
//  6. Release bank A in the same cycle as the 8th write to bank B
//     -> frame_valid stays 1, x0..x7 switch from A's data to B's next cycle.

Source files
------------

// File: rtl/fft8_input_framer_pkg.sv
// Shared constants and types for the 8-point FFT input framer.
package fft8_input_framer_pkg;

    localparam int FFT_NPT  = 8;
    localparam int FFT_DW   = 16;
    localparam int FFT_IDXW = 3;
    localparam int FFT_ERRW = 8;

    localparam logic [FFT_IDXW-1:0] IDX_LAST = FFT_IDXW'(FFT_NPT - 1);

    typedef enum logic {
        WR_FILL = 1'b0,
        WR_WAIT = 1'b1
    } wr_state_t;

endpackage

// File: rtl/fft8_frame_bank.sv
// 8 x DW sample register file: one indexed write port, synchronous clear,
// and all entries presented in parallel on a flattened read bus (entry 0 in the LSBs).
module fft8_frame_bank
    import fft8_input_framer_pkg::*;
#(
    parameter int DW  = FFT_DW,
    parameter int NPT = FFT_NPT
) (
    input  logic                i_clk,
    input  logic                i_clr,
    input  logic                i_we,
    input  logic [FFT_IDXW-1:0] i_idx,
    input  logic [DW-1:0]       i_dat,
    output logic [NPT*DW-1:0]   o_rd
);

    logic [DW-1:0] r_mem [NPT];

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            for (int i = 0; i < NPT; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_idx] <= i_dat;
        end
    end

    always_comb begin
        o_rd = '0;
        for (int i = 0; i < NPT; i++) begin
            o_rd[i*DW +: DW] = r_mem[i];
        end
    end

endmodule

// File: rtl/fft8_input_framer.sv
// Ping-pong framer: serial DW-bit samples into 8-sample frames presented in parallel.
// Frame is visible one cycle after its 8th accept; s_ready drops only while both banks hold frames.
module fft8_input_framer
    import fft8_input_framer_pkg::*;
#(
    parameter int DW   = FFT_DW,
    parameter int NPT  = FFT_NPT,
    parameter int ERRW = FFT_ERRW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [DW-1:0]   s_data,
    input  logic            s_valid,
    input  logic            s_last,
    output logic            s_ready,
    output logic [DW-1:0]   x0,
    output logic [DW-1:0]   x1,
    output logic [DW-1:0]   x2,
    output logic [DW-1:0]   x3,
    output logic [DW-1:0]   x4,
    output logic [DW-1:0]   x5,
    output logic [DW-1:0]   x6,
    output logic [DW-1:0]   x7,
    output logic            frame_valid,
    input  logic            frame_ready,
    output logic            frame_err,
    output logic [ERRW-1:0] err_cnt
);

    logic [FFT_IDXW-1:0] r_wr_idx;
    logic                r_wr_bank;
    logic                r_rd_bank;
    logic [1:0]          r_bank_full;
    logic                r_frame_err;
    logic [ERRW-1:0]     r_err_cnt;

    logic [FFT_IDXW-1:0] w_wr_idx_nxt;
    logic                w_wr_bank_nxt;
    logic                w_rd_bank_nxt;
    logic [1:0]          w_bank_full_nxt;
    logic [ERRW-1:0]     w_err_cnt_nxt;

    wr_state_t           w_wr_state;
    logic                w_accept;
    logic                w_complete;
    logic                w_discard;
    logic                w_release;
    logic [NPT*DW-1:0]   w_rd0;
    logic [NPT*DW-1:0]   w_rd1;
    logic [NPT*DW-1:0]   w_rd;

    // The write side waits exactly when the bank under the write pointer still holds a frame.
    always_comb begin
        w_wr_state = r_bank_full[r_wr_bank] ? WR_WAIT : WR_FILL;
    end

    assign s_ready    = en & ~rst & (w_wr_state == WR_FILL);
    assign w_accept   = s_valid & s_ready;
    assign w_complete = w_accept & (r_wr_idx == IDX_LAST);
    assign w_discard  = w_accept & s_last & (r_wr_idx != IDX_LAST);
    assign w_release  = r_bank_full[r_rd_bank] & frame_ready & en;

    // Release clears the read bank while completion sets the write bank; a full bank
    // never accepts writes, so the two updates always target different banks.
    always_comb begin
        w_bank_full_nxt = r_bank_full;
        w_wr_idx_nxt    = r_wr_idx;
        w_wr_bank_nxt   = r_wr_bank;
        w_rd_bank_nxt   = r_rd_bank;
        w_err_cnt_nxt   = r_err_cnt;
        if (w_release) begin
            w_bank_full_nxt[r_rd_bank] = 1'b0;
            w_rd_bank_nxt              = ~r_rd_bank;
        end
        if (w_complete) begin
            w_bank_full_nxt[r_wr_bank] = 1'b1;
            w_wr_bank_nxt              = ~r_wr_bank;
            w_wr_idx_nxt               = '0;
        end else if (w_discard) begin
            w_wr_idx_nxt = '0;
            if (r_err_cnt != '1) begin
                w_err_cnt_nxt = r_err_cnt + ERRW'(1);
            end
        end else if (w_accept) begin
            w_wr_idx_nxt = r_wr_idx + FFT_IDXW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_idx    <= '0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_bank_full <= '0;
            r_frame_err <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_wr_idx    <= w_wr_idx_nxt;
            r_wr_bank   <= w_wr_bank_nxt;
            r_rd_bank   <= w_rd_bank_nxt;
            r_bank_full <= w_bank_full_nxt;
            r_frame_err <= w_discard;
            r_err_cnt   <= w_err_cnt_nxt;
        end
    end

    fft8_frame_bank #(.DW(DW), .NPT(NPT)) u_bank0 (
        .i_clk (clk),
        .i_clr (rst),
        .i_we  (w_accept & ~r_wr_bank),
        .i_idx (r_wr_idx),
        .i_dat (s_data),
        .o_rd  (w_rd0)
    );

    fft8_frame_bank #(.DW(DW), .NPT(NPT)) u_bank1 (
        .i_clk (clk),
        .i_clr (rst),
        .i_we  (w_accept & r_wr_bank),
        .i_idx (r_wr_idx),
        .i_dat (s_data),
        .o_rd  (w_rd1)
    );

    assign w_rd        = r_rd_bank ? w_rd1 : w_rd0;
    assign x0          = w_rd[0*DW +: DW];
    assign x1          = w_rd[1*DW +: DW];
    assign x2          = w_rd[2*DW +: DW];
    assign x3          = w_rd[3*DW +: DW];
    assign x4          = w_rd[4*DW +: DW];
    assign x5          = w_rd[5*DW +: DW];
    assign x6          = w_rd[6*DW +: DW];
    assign x7          = w_rd[7*DW +: DW];
    assign frame_valid = r_bank_full[r_rd_bank];
    assign frame_err   = r_frame_err;
    assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_fft8_input_framer.sv
// Directed bench for fft8_input_framer: reset, streaming, backpressure, discard,
// enable freeze, mid-frame reset and coincident release/completion.
module tb_fft8_input_framer;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [15:0] x0, x1, x2, x3, x4, x5, x6, x7;
    logic        frame_valid;
    logic        frame_ready;
    logic        frame_err;
    logic [7:0]  err_cnt;
    logic [15:0] xs [8];

    int n_vec = 0;
    int n_err = 0;

    fft8_input_framer dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .x0          (x0),
        .x1          (x1),
        .x2          (x2),
        .x3          (x3),
        .x4          (x4),
        .x5          (x5),
        .x6          (x6),
        .x7          (x7),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_err   (frame_err),
        .err_cnt     (err_cnt)
    );

    assign xs[0] = x0;
    assign xs[1] = x1;
    assign xs[2] = x2;
    assign xs[3] = x3;
    assign xs[4] = x4;
    assign xs[5] = x5;
    assign xs[6] = x6;
    assign xs[7] = x7;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and hold it until accepted; returns one step after the accepting edge.
    task automatic push(input logic [15:0] d, input logic last);
        int n;
        s_data  = d;
        s_valid = 1'b1;
        s_last  = last;
        n = 0;
        #1;
        while (!s_ready && n < 200) begin
            cyc();
            n++;
        end
        if (n >= 200) chk("push_timeout_s_ready", {31'd0, s_ready}, 32'd1);
        cyc();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic chk_frame(input string tag, input logic [15:0] base);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_x%0d", tag, i), {16'd0, xs[i]}, {16'd0, base + 16'(i)});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; frame_ready = 1'b0;
        cyc(); cyc();
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
        chk("rst_x0", {16'd0, x0}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_s_ready", {31'd0, s_ready}, 32'd1);

        // 1: plain streaming with the consumer always ready
        frame_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(16'(i), 1'b0);
        chk("t1_valid", {31'd0, frame_valid}, 32'd1);
        chk_frame("t1", 16'd1);
        cyc();
        chk("t1_valid_drop", {31'd0, frame_valid}, 32'd0);

        // 2: both banks fill under backpressure, then drain
        frame_ready = 1'b0;
        for (int i = 1; i <= 16; i++) push(16'(i), 1'b0);
        chk("t2_s_ready_full", {31'd0, s_ready}, 32'd0);
        chk("t2_valid", {31'd0, frame_valid}, 32'd1);
        chk("t2_hold_x0", {16'd0, x0}, 32'd1);
        s_data = 16'd17; s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t2_stall", {31'd0, s_ready}, 32'd0);
        end
        chk("t2_stall_x7", {16'd0, x7}, 32'd8);
        frame_ready = 1'b1;
        cyc();
        frame_ready = 1'b0;
        #1;
        chk("t2_second_valid", {31'd0, frame_valid}, 32'd1);
        chk_frame("t2b", 16'd9);
        chk("t2_s_ready_freed", {31'd0, s_ready}, 32'd1);
        cyc();
        s_valid = 1'b0;
        chk("t2_held_x0", {16'd0, x0}, 32'd9);
        frame_ready = 1'b1;
        cyc();
        chk("t2_drained", {31'd0, frame_valid}, 32'd0);
        for (int i = 18; i <= 24; i++) push(16'(i), 1'b0);
        chk("t2_tail_valid", {31'd0, frame_valid}, 32'd1);
        chk_frame("t2c", 16'd17);
        cyc();
        chk("t2_tail_drop", {31'd0, frame_valid}, 32'd0);

        // 3: early s_last discards the partial frame
        for (int i = 0; i < 4; i++) push(16'h0100 + 16'(i), 1'b0);
        push(16'h0104, 1'b1);
        chk("t3_err_pulse", {31'd0, frame_err}, 32'd1);
        chk("t3_err_cnt", {24'd0, err_cnt}, 32'd1);
        chk("t3_no_valid", {31'd0, frame_valid}, 32'd0);
        cyc();
        chk("t3_err_clear", {31'd0, frame_err}, 32'd0);
        for (int i = 0; i < 8; i++) push(16'h0200 + 16'(i), 1'b0);
        chk("t3_valid", {31'd0, frame_valid}, 32'd1);
        chk_frame("t3", 16'h0200);
        chk("t3_err_cnt_hold", {24'd0, err_cnt}, 32'd1);
        cyc();

        // 4: enable low mid-frame freezes everything
        for (int i = 1; i <= 4; i++) push(16'(i), 1'b0);
        en = 1'b0; s_data = 16'hDEAD; s_valid = 1'b1;
        #1;
        chk("t4_s_ready_en0", {31'd0, s_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t4_frozen_valid", {31'd0, frame_valid}, 32'd0);
        end
        en = 1'b1; s_valid = 1'b0;
        for (int i = 5; i <= 8; i++) push(16'(i), 1'b0);
        chk("t4_valid", {31'd0, frame_valid}, 32'd1);
        chk_frame("t4", 16'd1);
        chk("t4_err_cnt", {24'd0, err_cnt}, 32'd1);
        cyc();

        // 5: reset mid-frame
        for (int i = 0; i < 4; i++) push(16'h0050 + 16'(i), 1'b0);
        rst = 1'b1;
        #1;
        chk("t5_s_ready_in_rst", {31'd0, s_ready}, 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk("t5_s_ready", {31'd0, s_ready}, 32'd1);
        chk("t5_x0", {16'd0, x0}, 32'd0);
        chk("t5_valid", {31'd0, frame_valid}, 32'd0);
        chk("t5_err_cnt", {24'd0, err_cnt}, 32'd0);
        for (int i = 0; i < 8; i++) push(16'h0060 + 16'(i), 1'b0);
        chk("t5_frame_valid", {31'd0, frame_valid}, 32'd1);
        chk_frame("t5", 16'h0060);
        cyc();

        // 6: release of one bank coincides with completion of the other
        frame_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(16'h00A0 + 16'(i), 1'b0);
        for (int i = 0; i < 7; i++) push(16'h00B0 + 16'(i), 1'b0);
        chk("t6_a_valid", {31'd0, frame_valid}, 32'd1);
        chk_frame("t6a", 16'h00A0);
        frame_ready = 1'b1;
        push(16'h00B7, 1'b0);
        chk("t6_b_valid", {31'd0, frame_valid}, 32'd1);
        chk_frame("t6b", 16'h00B0);
        cyc();
        chk("t6_drop", {31'd0, frame_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
